// File: rtl/frame_packer_pkg.sv
// Shared constants, frame layout indices and write-FSM state type for the frame packer.
package frame_packer_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hC0DE;

  localparam int HDR_IDX = 0;
  localparam int CNT_IDX = 1;
  localparam int CH0_IDX = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_packer_fifo.sv
// First-word-fall-through word FIFO with a registered fill level.
// Head entry reads as zero while empty so the stream outputs are clean after reset.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_pop;
  logic             full;

  always_comb begin
    do_pop   = pop_i & (level_q != '0);
    full     = (level_q == (AW+1)'(DEPTH));
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push_i, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (level_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

  // Space is reserved when a frame is accepted, so a push into a full FIFO is a design bug.
  push_while_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full));

endmodule

// File: rtl/frame_packer.sv
// Snapshots processed outputs on each result tick and streams them as framed 32-bit words.
// Whole frames are buffered; a tick without room for a whole frame is counted as a drop.
module frame_packer #(
  parameter int          NUM_CH     = 14,
  parameter int          FIFO_DEPTH = 256,
  parameter logic [15:0] SYNC_WORD  = frame_packer_pkg::SYNC_WORD
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          tick_i,
  input  logic [31:0]                   counter_i,
  input  logic [NUM_CH*32-1:0]          data_i,
  output logic [31:0]                   m_tdata_o,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic                          m_tlast_o,
  output logic                          busy_o,
  output logic [15:0]                   drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  import frame_packer_pkg::*;

  localparam int L     = NUM_CH + 2;
  localparam int IDX_W = $clog2(L);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            seq_q, seq_d;
  logic [15:0]            drop_q, drop_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [NUM_CH*32-1:0]   chan_q, chan_d;

  logic                   push;
  logic [32:0]            push_word;
  logic [32:0]            head_word;
  logic [LVL_W-1:0]       level;
  logic [LVL_W-1:0]       free;
  logic                   tick_seen;
  logic                   has_room;
  logic                   last_word;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    push      = 1'b0;
    push_word = '0;
    tick_seen = tick_i & enable_i;
    free      = LVL_W'(FIFO_DEPTH) - level;
    has_room  = (free >= LVL_W'(L));
    last_word = (idx_q == IDX_W'(L - 1));

    case (state_q)
      ST_IDLE: begin
        if (tick_seen) begin
          if (has_room) begin
            cnt_d   = counter_i;
            chan_d  = data_i;
            idx_d   = '0;
            state_d = ST_WRITE;
          end else begin
            drop_d = sat_inc16(drop_q);
          end
        end
      end
      ST_WRITE: begin
        push  = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(HDR_IDX)) begin
          push_word = {1'b0, SYNC_WORD, seq_q};
        end else if (idx_q == IDX_W'(CNT_IDX)) begin
          push_word = {1'b0, cnt_q};
        end else begin
          // Channels leave in order ch0..chN-1 by shifting the snapshot down one word per push.
          push_word = {last_word, chan_q[31:0]};
          chan_d    = chan_q >> 32;
        end
        if (last_word) begin
          seq_d   = seq_q + 16'd1;
          state_d = ST_IDLE;
        end
        if (tick_seen) drop_d = sat_inc16(drop_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
    end
  end

  // Stream handshake: a word transfers on a cycle with m_tvalid_o & m_tready_i; while valid
  // is high and ready low, data and last hold; valid never waits on ready.
  sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (m_tready_i),
    .rdata_o (head_word),
    .valid_o (m_tvalid_o),
    .level_o (level)
  );

  assign m_tdata_o    = head_word[31:0];
  assign m_tlast_o    = head_word[32];
  assign busy_o       = (state_q == ST_WRITE);
  assign drop_count_o = drop_q;
  assign fifo_level_o = level;

endmodule
